// File: rtl/dither_seq_ctrl.sv
// Sequencer for the gyro dither/demodulation engine: trigger generation, engine
// reset and configuration ownership, cycle-boundary detection and watchdog.
module dither_seq_ctrl #(
  parameter int          RST_CYC    = 4,
  parameter int          DISCARD    = 1,
  parameter int          WDOG_TRIGS = 4096,
  parameter logic [31:0] DEF_WAIT   = 32'd16,
  parameter logic [2:0]  DEF_AVG    = 3'd3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [31:0]        i_trig_period,
  input  logic               i_cfg_wr,
  input  logic [31:0]        i_cfg_wait_cnt,
  input  logic [2:0]         i_cfg_avg_sel,
  input  logic signed [31:0] i_eng_dither,
  input  logic signed [31:0] i_eng_data,
  output logic               o_trig,
  output logic               o_eng_rst_n,
  output logic [31:0]        o_wait_cnt,
  output logic [2:0]         o_avg_sel,
  output logic signed [31:0] o_data,
  output logic               o_valid,
  output logic               o_cfg_pend,
  output logic               o_err,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ERST = 2'd1, RUN = 2'd2} state_t;

  state_t      state;
  logic [31:0] sh_wait;
  logic [2:0]  sh_avg;
  logic [31:0] rst_cnt, trig_cnt, disc_cnt, wdog_cnt;
  logic        s_q, first_seen;

  logic [31:0] eff_per, nx_wait;
  logic [2:0]  nx_avg;
  logic        bnd, trig_hit, wdog_hit, bnd_restart, dither_unused;

  // Only the sign of the dither word matters.
  assign dither_unused = ^i_eng_dither[30:0];

  assign eff_per     = (i_trig_period < 32'd2) ? 32'd2 : i_trig_period;
  assign bnd         = s_q & ~i_eng_dither[31];
  assign trig_hit    = trig_cnt >= (eff_per - 32'd1);
  assign wdog_hit    = o_trig & ~bnd & (wdog_cnt >= 32'(WDOG_TRIGS - 1));
  assign bnd_restart = bnd & (o_cfg_pend | i_cfg_wr);
  // A write landing on the restart edge is folded into that restart.
  assign nx_wait     = i_cfg_wr ? i_cfg_wait_cnt : sh_wait;
  assign nx_avg      = i_cfg_wr ? i_cfg_avg_sel  : sh_avg;
  assign o_state     = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      sh_wait     <= DEF_WAIT;
      sh_avg      <= DEF_AVG;
      rst_cnt     <= '0;
      trig_cnt    <= '0;
      disc_cnt    <= '0;
      wdog_cnt    <= '0;
      s_q         <= 1'b0;
      first_seen  <= 1'b0;
      o_trig      <= 1'b0;
      o_eng_rst_n <= 1'b0;
      o_wait_cnt  <= DEF_WAIT;
      o_avg_sel   <= DEF_AVG;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_cfg_pend  <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_trig  <= 1'b0;
      s_q     <= i_eng_dither[31];
      if (i_cfg_wr) begin
        sh_wait    <= i_cfg_wait_cnt;
        sh_avg     <= i_cfg_avg_sel;
        o_cfg_pend <= 1'b1;
      end
      if (!i_en) begin
        state       <= IDLE;
        o_eng_rst_n <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= ERST;
            o_err      <= 1'b0;
            rst_cnt    <= '0;
            o_wait_cnt <= nx_wait;
            o_avg_sel  <= nx_avg;
            o_cfg_pend <= 1'b0;
          end
          ERST: begin
            if (rst_cnt >= 32'(RST_CYC - 1)) begin
              state       <= RUN;
              o_eng_rst_n <= 1'b1;
              trig_cnt    <= '0;
              disc_cnt    <= '0;
              wdog_cnt    <= '0;
              first_seen  <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt + 32'd1;
            end
          end
          RUN: begin
            o_trig   <= trig_hit;
            trig_cnt <= trig_hit ? 32'd0 : trig_cnt + 32'd1;
            if (bnd)         wdog_cnt <= '0;
            else if (o_trig) wdog_cnt <= wdog_cnt + 32'd1;
            // First edge after restart is the engine start, not a finished cycle.
            if (bnd) begin
              if (!first_seen)                  first_seen <= 1'b1;
              else if (disc_cnt < 32'(DISCARD)) disc_cnt   <= disc_cnt + 32'd1;
              else begin
                o_valid <= 1'b1;
                o_data  <= i_eng_data;
              end
            end
            if (bnd_restart || wdog_hit) begin
              state       <= ERST;
              o_eng_rst_n <= 1'b0;
              o_trig      <= 1'b0;
              rst_cnt     <= '0;
              o_wait_cnt  <= nx_wait;
              o_avg_sel   <= nx_avg;
              o_cfg_pend  <= 1'b0;
            end
            if (wdog_hit) o_err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dither_seq_ctrl.sv
// Directed bench for dither_seq_ctrl: cycle vector table plus engine-model,
// watchdog and reset sequences.
module tb_dither_seq_ctrl;
  localparam int RST_CYC = 4;
  localparam int DISCARD = 1;
  localparam int NV      = 35;

  logic               i_clk = 1'b0, i_rst_n = 1'b0, i_en = 1'b0, i_cfg_wr = 1'b0;
  logic [31:0]        i_trig_period = 32'd100, i_cfg_wait_cnt = '0;
  logic [2:0]         i_cfg_avg_sel = '0;
  logic signed [31:0] i_eng_dither = -32'sd1, i_eng_data = '0;
  logic               o_trig, o_eng_rst_n, o_valid, o_cfg_pend, o_err;
  logic [31:0]        o_wait_cnt;
  logic [2:0]         o_avg_sel;
  logic signed [31:0] o_data;
  logic [1:0]         o_state;

  dither_seq_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_trig_period(i_trig_period),
    .i_cfg_wr(i_cfg_wr), .i_cfg_wait_cnt(i_cfg_wait_cnt), .i_cfg_avg_sel(i_cfg_avg_sel),
    .i_eng_dither(i_eng_dither), .i_eng_data(i_eng_data), .o_trig(o_trig),
    .o_eng_rst_n(o_eng_rst_n), .o_wait_cnt(o_wait_cnt), .o_avg_sel(o_avg_sel),
    .o_data(o_data), .o_valid(o_valid), .o_cfg_pend(o_cfg_pend), .o_err(o_err),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic en, wr; logic [31:0] cw; logic [2:0] ca; logic d; logic [31:0] din;
    logic [1:0] st; logic rn, v; logic [31:0] dout; logic pend; logic [31:0] w; logic [2:0] a;
  } vec_t;
  vec_t tv[NV];

  function automatic vec_t mk(input logic en, wr, input logic [31:0] cw, input logic [2:0] ca,
                              input logic d, input logic [31:0] din, input logic [1:0] st,
                              input logic rn, v, input logic [31:0] dout, input logic pend,
                              input logic [31:0] w, input logic [2:0] a);
    vec_t r;
    r.en = en; r.wr = wr; r.cw = cw; r.ca = ca; r.d = d; r.din = din; r.st = st;
    r.rn = rn; r.v = v; r.dout = dout; r.pend = pend; r.w = w; r.a = a;
    return r;
  endfunction

  // Engine model and running checks shared by the multi-cycle sequences.
  int          eng_k = 0, eng_cyc = 0, run_clk = 0, last_trig = 0, tper = 10;
  int          erst_n = 0, low_run = 0, n_valid = 0, n_trig = 0;
  logic        eng_on = 1'b1, exp_v = 1'b0, prev_rn = 1'b0, from_run = 1'b0, seen_trig = 1'b0;
  logic [31:0] exp_d = '0;

  task step();
    @(posedge i_clk); #1;
    chk("valid", o_valid, exp_v);
    if (exp_v) chk("data", o_data, exp_d);
    if (o_valid) n_valid++;
    exp_v = 1'b0;
    if (o_state == 2'd1) erst_n++;
    if (!o_eng_rst_n) low_run++;
    if (!o_eng_rst_n && prev_rn) from_run = 1'b1;
    if (o_eng_rst_n && !prev_rn) begin
      chk("erst_len", erst_n, RST_CYC);
      if (from_run) chk("rst_low", low_run, RST_CYC);
      erst_n = 0; low_run = 0; from_run = 1'b0; run_clk = 0; seen_trig = 1'b0;
    end else if (o_eng_rst_n) run_clk++;
    if (o_trig) begin
      if (!seen_trig) chk("first_trig", run_clk, tper);
      else            chk("trig_gap", run_clk - last_trig, tper);
      seen_trig = 1'b1; last_trig = run_clk;
    end
    if (eng_on) begin
      if (!o_eng_rst_n) begin
        eng_k = 0; eng_cyc = 0; i_eng_dither = -32'sd1;
      end else if (o_trig) begin
        eng_k++;
        if (eng_k % 8 == 0) i_eng_data = {o_wait_cnt[7:0], 5'b0, o_avg_sel, eng_k[15:0]};
        if (eng_k % 8 == 1) begin
          i_eng_dither = 32'sd1;
          if (eng_k > 1) begin
            eng_cyc++;
            if (eng_cyc > DISCARD) begin exp_v = 1'b1; exp_d = i_eng_data; end
          end
        end
        if (eng_k % 8 == 5) i_eng_dither = -32'sd1;
      end
    end
    prev_rn = o_eng_rst_n;
  endtask

  task chk_reset_vals(input string tag);
    chk({tag, ".rst_n"}, o_eng_rst_n, 0);
    chk({tag, ".trig"},  o_trig, 0);
    chk({tag, ".wait"},  o_wait_cnt, 16);
    chk({tag, ".avg"},   o_avg_sel, 3);
    chk({tag, ".data"},  o_data, 0);
    chk({tag, ".valid"}, o_valid, 0);
    chk({tag, ".pend"},  o_cfg_pend, 0);
    chk({tag, ".err"},   o_err, 0);
    chk({tag, ".state"}, o_state, 0);
  endtask

  initial begin
    //            en wr cw  ca d din       st rn v dout      pd w   a
    tv[0]  = mk(0, 0, 0,  0, 1, 0,        0, 0, 0, 0,        0, 16, 3);
    tv[1]  = mk(0, 1, 20, 2, 1, 0,        0, 0, 0, 0,        1, 16, 3);
    tv[2]  = mk(1, 0, 0,  0, 1, 0,        1, 0, 0, 0,        0, 20, 2);
    tv[3]  = mk(1, 0, 0,  0, 1, 0,        1, 0, 0, 0,        0, 20, 2);
    tv[4]  = mk(1, 0, 0,  0, 1, 0,        1, 0, 0, 0,        0, 20, 2);
    tv[5]  = mk(1, 0, 0,  0, 1, 0,        1, 0, 0, 0,        0, 20, 2);
    tv[6]  = mk(1, 0, 0,  0, 1, 0,        2, 1, 0, 0,        0, 20, 2);
    tv[7]  = mk(1, 0, 0,  0, 0, 0,        2, 1, 0, 0,        0, 20, 2);
    tv[8]  = mk(1, 0, 0,  0, 0, 0,        2, 1, 0, 0,        0, 20, 2);
    tv[9]  = mk(1, 0, 0,  0, 1, 0,        2, 1, 0, 0,        0, 20, 2);
    tv[10] = mk(1, 0, 0,  0, 1, 0,        2, 1, 0, 0,        0, 20, 2);
    tv[11] = mk(1, 0, 0,  0, 0, 32'h111,  2, 1, 0, 0,        0, 20, 2);
    tv[12] = mk(1, 0, 0,  0, 1, 32'h111,  2, 1, 0, 0,        0, 20, 2);
    tv[13] = mk(1, 0, 0,  0, 0, 32'h222,  2, 1, 1, 32'h222,  0, 20, 2);
    tv[14] = mk(1, 0, 0,  0, 0, 32'h333,  2, 1, 0, 32'h222,  0, 20, 2);
    tv[15] = mk(1, 1, 32, 5, 1, 32'h333,  2, 1, 0, 32'h222,  1, 20, 2);
    tv[16] = mk(1, 0, 0,  0, 0, 32'h444,  1, 0, 1, 32'h444,  0, 32, 5);
    tv[17] = mk(1, 0, 0,  0, 0, 32'h444,  1, 0, 0, 32'h444,  0, 32, 5);
    tv[18] = mk(1, 1, 7,  1, 0, 32'h444,  1, 0, 0, 32'h444,  1, 32, 5);
    tv[19] = mk(1, 0, 0,  0, 0, 32'h444,  1, 0, 0, 32'h444,  1, 32, 5);
    tv[20] = mk(1, 0, 0,  0, 0, 32'h444,  2, 1, 0, 32'h444,  1, 32, 5);
    tv[21] = mk(1, 0, 0,  0, 1, 32'h444,  2, 1, 0, 32'h444,  1, 32, 5);
    tv[22] = mk(1, 0, 0,  0, 0, 32'h555,  1, 0, 0, 32'h444,  0, 7,  1);
    tv[23] = mk(1, 1, 9,  6, 0, 32'h555,  1, 0, 0, 32'h444,  1, 7,  1);
    tv[24] = mk(0, 0, 0,  0, 0, 32'h555,  0, 0, 0, 32'h444,  1, 7,  1);
    tv[25] = mk(1, 1, 12, 4, 0, 32'h555,  1, 0, 0, 32'h444,  0, 12, 4);
    tv[26] = mk(1, 0, 0,  0, 0, 32'h555,  1, 0, 0, 32'h444,  0, 12, 4);
    tv[27] = mk(1, 0, 0,  0, 0, 32'h555,  1, 0, 0, 32'h444,  0, 12, 4);
    tv[28] = mk(1, 0, 0,  0, 0, 32'h555,  1, 0, 0, 32'h444,  0, 12, 4);
    tv[29] = mk(1, 0, 0,  0, 0, 32'h555,  2, 1, 0, 32'h444,  0, 12, 4);
    tv[30] = mk(1, 0, 0,  0, 1, 32'h555,  2, 1, 0, 32'h444,  0, 12, 4);
    tv[31] = mk(1, 0, 0,  0, 0, 32'h555,  2, 1, 0, 32'h444,  0, 12, 4);
    tv[32] = mk(1, 0, 0,  0, 1, 32'h555,  2, 1, 0, 32'h444,  0, 12, 4);
    tv[33] = mk(1, 1, 8,  7, 0, 32'h666,  1, 0, 0, 32'h444,  0, 8,  7);
    tv[34] = mk(0, 0, 0,  0, 0, 32'h666,  0, 0, 0, 32'h444,  0, 8,  7);

    #12 chk_reset_vals("reset");
    #10 i_rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      i_en = tv[i].en; i_cfg_wr = tv[i].wr; i_cfg_wait_cnt = tv[i].cw;
      i_cfg_avg_sel = tv[i].ca; i_eng_data = tv[i].din;
      i_eng_dither = tv[i].d ? -32'sd1 : 32'sd1;
      @(posedge i_clk); #1;
      chk($sformatf("v%0d.state", i), o_state, tv[i].st);
      chk($sformatf("v%0d.rst_n", i), o_eng_rst_n, tv[i].rn);
      chk($sformatf("v%0d.trig", i),  o_trig, 0);
      chk($sformatf("v%0d.valid", i), o_valid, tv[i].v);
      chk($sformatf("v%0d.data", i),  o_data, tv[i].dout);
      chk($sformatf("v%0d.pend", i),  o_cfg_pend, tv[i].pend);
      chk($sformatf("v%0d.wait", i),  o_wait_cnt, tv[i].w);
      chk($sformatf("v%0d.avg", i),   o_avg_sel, tv[i].a);
      chk($sformatf("v%0d.err", i),   o_err, 0);
    end
    i_cfg_wr = 1'b0;

    // Engine-model run: startup, then a config write in RUN.
    i_rst_n = 1'b0; i_en = 1'b0; i_trig_period = 32'd10; tper = 10;
    #4 i_rst_n = 1'b1; i_en = 1'b1;
    for (int i = 0; i < 3000 && n_valid < 3; i++) step();
    chk("valid_cnt3", n_valid, 3);
    chk("data3", o_data, 32'h10030020);
    for (int i = 0; i < 200 && (eng_k % 8) != 3; i++) step();
    i_cfg_wr = 1'b1; i_cfg_wait_cnt = 32'd32; i_cfg_avg_sel = 3'd5;
    step();
    i_cfg_wr = 1'b0;
    for (int i = 0; i < 500 && o_state == 2'd2; i++) begin
      chk("pend_hold", o_cfg_pend, 1);
      step();
    end
    chk("cfg_state", o_state, 1);
    chk("cfg_rst_n", o_eng_rst_n, 0);
    chk("cfg_wait", o_wait_cnt, 32);
    chk("cfg_avg", o_avg_sel, 5);
    chk("cfg_pend", o_cfg_pend, 0);
    chk("valid_cnt4", n_valid, 4);
    for (int i = 0; i < 2000 && n_valid < 5; i++) step();
    chk("valid_cnt5", n_valid, 5);
    chk("data5", o_data, 32'h20050010);
    step(); step();
    #2 i_rst_n = 1'b0;
    #1 chk_reset_vals("async");

    // Watchdog with the dither stuck at -1 and degenerate periods.
    eng_on = 1'b0; i_eng_dither = -32'sd1; i_trig_period = 32'd0; tper = 2;
    prev_rn = 1'b0; from_run = 1'b0; low_run = 0; erst_n = 0; n_trig = 0;
    #3 i_rst_n = 1'b1;
    for (int i = 0; i < 12000 && !o_err; i++) begin
      if (i == 300) i_trig_period = 32'd1;
      if (i == 600) i_trig_period = 32'd2;
      step();
      if (o_trig) n_trig++;
    end
    chk("wdog_trigs", n_trig, 4096);
    chk("wdog_state", o_state, 1);
    chk("wdog_rst_n", o_eng_rst_n, 0);
    chk("wdog_err", o_err, 1);
    i_en = 1'b0;
    step();
    chk("dis_state", o_state, 0);
    chk("dis_err", o_err, 1);
    chk("dis_trig", o_trig, 0);
    i_en = 1'b1;
    step();
    chk("reen_state", o_state, 1);
    chk("reen_err", o_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
